sync_reg_wr_arbiter: RTL and testbench

SYNC_REG_WR_ARBITER -- requirements
Module: sync_reg_wr_arbiter

---
 rtl/sync_reg_wr_arbiter.sv | 153 +++++++++++++++
 tb/tb_sync_reg_wr_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_reg_wr_arbiter.sv
// Write-side arbiter for a shared single-entry sync register.
// NREQ requesters compete round-robin. The winner's word is written into the
// register, which then gets one transfer cycle. The arbiter then waits for the
// read domain to toggle r_ack_tgl before it accepts the next request. A
// watchdog releases the register if no ack arrives. Acks that arrive outside
// WAIT_ACK are flagged as protocol errors.
module sync_reg_wr_arbiter #(
  parameter int SIZE    = 4,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    w_clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*SIZE-1:0]    req_data,
  input  logic                    r_ack_tgl,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    sr_w_en,
  output logic [SIZE-1:0]         sr_w_data,
  output logic                    busy,
  output logic                    timeout_err,
  output logic                    proto_err
);

  localparam int             IDW         = $clog2(NREQ);
  localparam logic [IDW-1:0] LAST_RST    = IDW'(NREQ - 1);
  localparam logic [7:0]     TIMEOUT_CNT = 8'(TIMEOUT);
  localparam bit             TIMEOUT_EN  = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    XFER     = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  state_t state;

  logic ack_sync1;
  logic ack_sync2;
  logic ack_hist;
  logic ack_pulse;

  logic [IDW-1:0]  last_gnt;
  logic [7:0]      wait_cnt;
  logic [7:0]      wait_cnt_inc;

  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  cand;
  logic [NREQ-1:0] win_onehot;
  logic [SIZE-1:0] win_data;

  // Bring the read-domain toggle into w_clk and keep one history flop for edge detection.
  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      ack_sync1 <= 1'b0;
      ack_sync2 <= 1'b0;
      ack_hist  <= 1'b0;
    end else begin
      ack_sync1 <= r_ack_tgl;
      ack_sync2 <= ack_sync1;
      ack_hist  <= ack_sync2;
    end
  end

  // Each toggle of r_ack_tgl shows up here as a single-cycle pulse.
  assign ack_pulse = ack_sync2 ^ ack_hist;

  assign wait_cnt_inc = wait_cnt + 8'd1;

  // Busy is decoded from the state alone, so an async reset clears it at once.
  assign busy = (state != IDLE);

  // Round-robin search that starts just after the last winner and wraps around.
  always_comb begin
    win_found  = 1'b0;
    win_id     = '0;
    cand       = '0;
    win_onehot = '0;
    win_data   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(last_gnt) + 1 + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found        = 1'b1;
        win_id           = cand;
        win_onehot[cand] = 1'b1;
        win_data         = req_data[int'(cand)*SIZE +: SIZE];
      end
    end
  end

  // Main control FSM with registered grant, write strobe, data and error flags.
  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= '0;
      gnt_id      <= '0;
      sr_w_en     <= 1'b0;
      sr_w_data   <= '0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
      wait_cnt    <= '0;
      last_gnt    <= LAST_RST;
    end else begin
      sr_w_en <= 1'b0;
      gnt     <= '0;

      if (ack_pulse && (state != WAIT_ACK)) begin
        proto_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (win_found) begin
            state     <= WRITE;
            sr_w_en   <= 1'b1;
            gnt       <= win_onehot;
            gnt_id    <= win_id;
            last_gnt  <= win_id;
            sr_w_data <= win_data;
          end
        end

        WRITE: begin
          state <= XFER;
        end

        XFER: begin
          state    <= WAIT_ACK;
          wait_cnt <= '0;
        end

        WAIT_ACK: begin
          if (ack_pulse) begin
            state <= IDLE;
          end else if (TIMEOUT_EN && (wait_cnt_inc == TIMEOUT_CNT)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt_inc;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_reg_wr_arbiter.sv
// Directed bench for sync_reg_wr_arbiter (SIZE=4, NREQ=4, TIMEOUT=8).
// Inputs are driven and outputs sampled 1 ns after each rising w_clk edge.
`timescale 1ns/1ps
module tb_sync_reg_wr_arbiter;

  localparam int SIZE    = 4;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  logic        w_clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic        r_ack_tgl;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        sr_w_en;
  logic [3:0]  sr_w_data;
  logic        busy;
  logic        timeout_err;
  logic        proto_err;

  int tests_run    = 0;
  int tests_failed = 0;

  sync_reg_wr_arbiter #(
    .SIZE    (SIZE),
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .w_clk       (w_clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .r_ack_tgl   (r_ack_tgl),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .sr_w_en     (sr_w_en),
    .sr_w_data   (sr_w_data),
    .busy        (busy),
    .timeout_err (timeout_err),
    .proto_err   (proto_err)
  );

  // Free-running write-domain clock, 10 ns period.
  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] d);
    req      = r;
    req_data = d;
  endtask

  task automatic toggleAck();
    r_ack_tgl = ~r_ack_tgl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyReset(input string tag);
    rst       = 1'b1;
    req       = '0;
    req_data  = '0;
    r_ack_tgl = 1'b0;
    #1;
    checkOutput({tag, "_sr_w_en"},     32'(sr_w_en),     32'd0);
    checkOutput({tag, "_gnt"},         32'(gnt),         32'd0);
    checkOutput({tag, "_busy"},        32'(busy),        32'd0);
    checkOutput({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    checkOutput({tag, "_proto_err"},   32'(proto_err),   32'd0);
    step();
    step();
    checkOutput({tag, "_gnt_id"},    32'(gnt_id),    32'd0);
    checkOutput({tag, "_sr_w_data"}, 32'(sr_w_data), 32'd0);
    rst = 1'b0;
  endtask

  // Expects IDLE with a request pending; runs one full grant and acks it in WAIT_ACK.
  task automatic grantAndAck(input string tag, input int exp_id, input logic [3:0] exp_data);
    step();
    checkOutput({tag, "_w_en"},   32'(sr_w_en),   32'd1);
    checkOutput({tag, "_gnt"},    32'(gnt),       32'd1 << exp_id);
    checkOutput({tag, "_gnt_id"}, 32'(gnt_id),    32'(exp_id));
    checkOutput({tag, "_data"},   32'(sr_w_data), 32'(exp_data));
    step();
    checkOutput({tag, "_xfer_w_en"}, 32'(sr_w_en), 32'd0);
    checkOutput({tag, "_xfer_gnt"},  32'(gnt),     32'd0);
    checkOutput({tag, "_xfer_busy"}, 32'(busy),    32'd1);
    step();
    toggleAck();
    step();
    step();
    checkOutput({tag, "_wait_busy"}, 32'(busy), 32'd1);
    step();
    checkOutput({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int pulses;
    int last_pulse;
    int toggle_at;

    rst       = 1'b1;
    req       = '0;
    req_data  = '0;
    r_ack_tgl = 1'b0;

    // Reset state
    applyReset("rst0");

    // Single request: requester 2, data A
    applyStimulus(4'b0100, 16'h0A00);
    grantAndAck("single", 2, 4'hA);
    applyStimulus(4'b0000, 16'h0000);
    checkOutput("single_hold_data", 32'(sr_w_data), 32'hA);

    // Timeout: requester 0 granted, never acked
    applyStimulus(4'b0001, 16'h0005);
    step();
    checkOutput("to_w_en",   32'(sr_w_en), 32'd1);
    checkOutput("to_gnt_id", 32'(gnt_id),  32'd0);
    applyStimulus(4'b0000, 16'h0000);
    step();
    step();
    repeat (7) step();
    checkOutput("to_busy_before", 32'(busy),        32'd1);
    checkOutput("to_err_before",  32'(timeout_err), 32'd0);
    step();
    checkOutput("to_busy_after",  32'(busy),        32'd0);
    checkOutput("to_err_after",   32'(timeout_err), 32'd1);
    repeat (3) step();
    checkOutput("to_err_sticky",  32'(timeout_err), 32'd1);
    applyStimulus(4'b0010, 16'h00B0);
    grantAndAck("after_to", 1, 4'hB);
    applyStimulus(4'b0000, 16'h0000);
    checkOutput("to_err_still", 32'(timeout_err), 32'd1);
    checkOutput("to_no_proto",  32'(proto_err),   32'd0);

    // Protocol error: ack toggle while idle
    toggleAck();
    step();
    step();
    checkOutput("proto_early", 32'(proto_err), 32'd0);
    step();
    checkOutput("proto_set",  32'(proto_err), 32'd1);
    checkOutput("proto_busy", 32'(busy),      32'd0);
    checkOutput("proto_gnt",  32'(gnt),       32'd0);
    step();
    checkOutput("proto_w_en", 32'(sr_w_en),   32'd0);

    // Round-robin with all four requesting
    applyReset("rst1");
    applyStimulus(4'b1111, 16'h4321);
    grantAndAck("rr0", 0, 4'h1);
    grantAndAck("rr1", 1, 4'h2);
    grantAndAck("rr2", 2, 4'h3);
    grantAndAck("rr3", 3, 4'h4);
    grantAndAck("rr4", 0, 4'h1);
    applyStimulus(4'b0000, 16'h0000);
    checkOutput("rr_proto", 32'(proto_err), 32'd0);

    // Reset asserted during WRITE
    applyReset("rst2");
    applyStimulus(4'b0001, 16'h0007);
    step();
    checkOutput("mid_w_en", 32'(sr_w_en), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_w_en", 32'(sr_w_en), 32'd0);
    checkOutput("mid_rst_gnt",  32'(gnt),     32'd0);
    checkOutput("mid_rst_busy", 32'(busy),    32'd0);
    applyStimulus(4'b0010, 16'h0090);
    step();
    checkOutput("mid_hold_w_en", 32'(sr_w_en), 32'd0);
    checkOutput("mid_hold_gnt",  32'(gnt),     32'd0);
    rst = 1'b0;
    grantAndAck("mid_rel", 1, 4'h9);
    applyStimulus(4'b0000, 16'h0000);

    // Back-to-back: requester 0 held, ack four cycles after each write strobe
    applyReset("rst3");
    applyStimulus(4'b0001, 16'h000C);
    pulses     = 0;
    last_pulse = 0;
    toggle_at  = -1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (sr_w_en) begin
        if (pulses > 0) begin
          checkOutput("b2b_spacing", 32'(c - last_pulse), 32'd8);
        end
        checkOutput("b2b_gnt_id", 32'(gnt_id),    32'd0);
        checkOutput("b2b_data",   32'(sr_w_data), 32'hC);
        pulses++;
        last_pulse = c;
        toggle_at  = c + 4;
      end
      if (c == toggle_at) begin
        toggleAck();
      end
    end
    checkOutput("b2b_count", 32'(pulses), 32'd4);
    applyStimulus(4'b0000, 16'h0000);
    repeat (6) step();
    checkOutput("b2b_idle",    32'(busy),        32'd0);
    checkOutput("b2b_proto",   32'(proto_err),   32'd0);
    checkOutput("b2b_timeout", 32'(timeout_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
